mealy_1101: RTL and testbench

// - Serial pattern detector: watches a 1-bit stream x, sampled once per clk rising edge.
// - Raises z combinationally in the cycle whose x bit completes the sequence 1-1-0-1.
// - This is a Mealy machine, so z depends on the current state and the live x.
// - Standalone leaf block, used as a detection flag for downstream control logic.

---
 rtl/mealy_1101_pkg.sv | 29 ++
 rtl/mealy_1101.sv | 88 ++++++++
 tb/tb_mealy_1101.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mealy_1101_pkg.sv
// ---------------------------------------------------------------------------
// mealy_1101_pkg
//
// Purpose:
//   Shared types and constants for the mealy_1101 serial pattern detector.
//
// Contents:
//   state_t  - 2-bit state encoding of the detector
//                S0 : idle / no partial match
//                S1 : "1" received
//                S2 : "11" received
//                S3 : "110" received
//   PATTERN  - the detected sequence, MSB received first
//
// Configuration:
//   MEALY_1101_OVERLAP_EN is consumed by mealy_1101.sv, not by this package.
// ---------------------------------------------------------------------------
package mealy_1101_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage : mealy_1101_pkg

// File: rtl/mealy_1101.sv
// ---------------------------------------------------------------------------
// mealy_1101
//
// Purpose:
//   Serial pattern detector for the sequence 1-1-0-1 (MSB first). One bit of
//   x is consumed on every rising edge of clk. z is a Mealy output: it is
//   raised combinationally in the same cycle that the final '1' is present
//   on x while the machine holds "110".
//
// Ports:
//   clk    in   1  single clock, state updates on the rising edge
//   reset  in   1  synchronous, active-high reset
//   x      in   1  serial data bit
//   z      out  1  detection flag, combinational from state and live x
//
// Configuration:
//   MEALY_1101_OVERLAP_EN
//     defined   : overlapping detection, the trailing '1' of a match is
//                 reused as the first bit of the next one (S3 -x=1-> S1).
//     undefined : non-overlapping detection, a match returns to S0.
// ---------------------------------------------------------------------------
module mealy_1101
    import mealy_1101_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic z
);

    state_t state;
    state_t state_next;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = S0;
        z          = 1'b0;

        case (state)
            S0: begin
                state_next = x ? S1 : S0;
            end

            S1: begin
                state_next = x ? S2 : S0;
            end

            // Extra 1s keep the "11" prefix alive, so stay here.
            S2: begin
                state_next = x ? S2 : S3;
            end

            S3: begin
                if (x == PATTERN[0]) begin
                    // Reset is folded in so a match can never be flagged
                    // while the register is being cleared.
                    z = ~reset;
`ifdef MEALY_1101_OVERLAP_EN
                    state_next = S1;
`else
                    state_next = S0;
`endif
                end else begin
                    state_next = S0;
                end
            end

            default: begin
                state_next = S0;
                z          = 1'b0;
            end
        endcase
    end

endmodule : mealy_1101

// File: tb/tb_mealy_1101.sv
// ---------------------------------------------------------------------------
// tb_mealy_1101
//
// Self-checking bench for mealy_1101. A reference model tracks the last
// three accepted bits and the number of bits since the last restart; the
// expected z for every driven bit goes into exp_q and is popped when z is
// sampled in the middle of the cycle.
// ---------------------------------------------------------------------------
module tb_mealy_1101;

`ifdef MEALY_1101_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    logic clk;
    logic reset;
    logic x;
    logic z;

    int errors = 0;
    int checks = 0;

    logic exp_q[$];

    // Reference model state: history of accepted bits since last restart.
    logic [2:0] hist     = 3'b000;
    int         hist_len = 0;

    int long_hits;

    mealy_1101 dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .z     (z)
    );

    // -----------------------------------------------------------------------
    // Clock and initial input values
    // -----------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    function automatic logic model_z(input logic r, input logic b);
        return (!r && b && (hist_len >= 3) && (hist == 3'b110));
    endfunction

    function automatic void model_step(input logic r, input logic b);
        if (r) begin
            hist     = 3'b000;
            hist_len = 0;
        end else if (model_z(r, b) && !OVERLAP) begin
            hist     = 3'b000;
            hist_len = 0;
        end else begin
            hist = {hist[1:0], b};
            if (hist_len < 3) hist_len++;
        end
    endfunction

    // -----------------------------------------------------------------------
    // Scoreboard check: pop the oldest expectation and compare with z
    // -----------------------------------------------------------------------
    task automatic check_z(input string tag);
        logic expv;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed z=%b", tag, z);
        end else begin
            expv = exp_q.pop_front();
            assert (z === expv) else begin
                errors++;
                $error("FAIL %s: observed z=%b expected z=%b", tag, z, expv);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Drivers
    // -----------------------------------------------------------------------
    // Apply one bit mid-cycle, check z before the edge, then let it clock in.
    task automatic drive_bit(input logic r, input logic b, input string tag);
        @(negedge clk);
        reset = r;
        x     = b;
        exp_q.push_back(model_z(r, b));
        #1;
        check_z(tag);
        if (z === 1'b1) long_hits++;
        @(posedge clk);
        model_step(r, b);
    endtask

    // Move x within one cycle: z must follow each value, only b_final clocks.
    task automatic drive_glitch(input logic b_first, input logic b_final,
                                input string tag);
        @(negedge clk);
        reset = 1'b0;
        x     = b_first;
        exp_q.push_back(model_z(1'b0, b_first));
        #1;
        check_z({tag, "_first"});
        x = b_final;
        exp_q.push_back(model_z(1'b0, b_final));
        #1;
        check_z({tag, "_final"});
        @(posedge clk);
        model_step(1'b0, b_final);
    endtask

    task automatic drive_seq(input logic [15:0] bits, input int n,
                             input string tag);
        for (int i = 0; i < n; i++) begin
            drive_bit(1'b0, bits[n-1-i], $sformatf("%s[%0d]", tag, i));
        end
    endtask

    // -----------------------------------------------------------------------
    // Directed stimulus
    // -----------------------------------------------------------------------
    initial begin
        int exp_hits;
        reset     = 1'b1;
        x         = 1'b1;
        long_hits = 0;

        // Reset held with x=1 (first check is before any edge: state unknown).
        drive_bit(1'b1, 1'b1, "rst_x1_a");
        drive_bit(1'b1, 1'b1, "rst_x1_b");
        // Reset held with x toggling.
        drive_bit(1'b1, 1'b0, "rst_tog_a");
        drive_bit(1'b1, 1'b1, "rst_tog_b");

        // Basic match straight out of reset.
        drive_seq(16'b1101, 4, "basic");

        // Long stream; count observed detections separately.
        drive_bit(1'b1, 1'b0, "rst_long");
        long_hits = 0;
        drive_seq(16'b0110110110011010, 16, "long");
        exp_hits = OVERLAP ? 3 : 2;
        checks++;
        assert (long_hits == exp_hits) else begin
            errors++;
            $error("FAIL long_hits: observed %0d expected %0d", long_hits, exp_hits);
        end

        // Repeated ones then 0,1.
        drive_bit(1'b1, 1'b0, "rst_rep");
        drive_seq(16'b111101, 6, "rep_ones");

        // Near misses.
        drive_bit(1'b1, 1'b0, "rst_near");
        drive_seq(16'b11001011, 8, "near");

        // Reset mid-sequence: reset lands while holding "110" with x=1.
        drive_bit(1'b1, 1'b0, "rst_mid0");
        drive_seq(16'b110, 3, "mid_pre");
        drive_bit(1'b1, 1'b1, "mid_rst");
        drive_bit(1'b0, 1'b1, "mid_post");
        drive_seq(16'b1101, 4, "mid_match");

        // z follows x combinationally while in S3.
        drive_bit(1'b1, 1'b0, "rst_glitch");
        drive_seq(16'b110, 3, "glitch_pre");
        drive_glitch(1'b0, 1'b1, "glitch_hit");
        drive_glitch(1'b1, 1'b0, "glitch_drop");

        // Back-to-back patterns in the stream 1101101.
        drive_bit(1'b1, 1'b0, "rst_b2b");
        drive_seq(16'b1101101, 7, "b2b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mealy_1101
